// File: rtl/frame_pkg.sv
// Shared constants for the UART frame assembler: frame length, opcodes,
// error codes and the assembler FSM state encoding.
// No logic; imported by uart_frame_assembler.
package frame_pkg;

  localparam int FRAME_BYTES = 9;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_HEADER  = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_COLLECT = 2'b01;
  localparam logic [1:0] ST_HOLD    = 2'b10;

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap timer: counts consecutive enabled cycles without a clear.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th idle cycle.
// Backpressure: none; clear restarts the count, !enable holds it at 0.
// Ports: clk, reset (sync, active-low), clear, enable, expired.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts idle cycles already seen before the current one, so the
  // cycle in which cnt_q == LAST is the TIMEOUT_CYCLES-th idle cycle.
  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles 9-byte UART frames (header, A MSB-first, B MSB-first) for a downstream FSM.
// Latency: frame_valid one cycle after the 9th byte strobe; errors pulse one cycle after the cause.
// Backpressure: frame held until frame_ready; bytes arriving while held are dropped as overrun.
// Ports: clk, reset (sync, active-low), byte_in/byte_valid in, frame_ready in,
//        frame_valid/op/operand_a/operand_b/byte_count/busy out, err_pulse/err_code out.
module uart_frame_assembler
  import frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [1:0]  op,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [3:0]  byte_count,
  output logic        busy,
  output logic        err_pulse,
  output logic [1:0]  err_code
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_pulse_q, err_pulse_d;
  logic [1:0]  err_code_q, err_code_d;

  logic timer_expired;
  logic handshake;

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (byte_valid),
    .enable (state_q == ST_COLLECT),
    .expired(timer_expired)
  );

  assign handshake = (state_q == ST_HOLD) && frame_ready;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      ST_COLLECT: begin
        // A byte in the expiry cycle wins over the timeout.
        if (byte_valid) begin
          // byte_count 1..4 -> bytes 2..5 go to A; 5..8 -> bytes 6..9 go to B.
          if (cnt_q < 4'd5) begin
            a_d = {a_q[23:0], byte_in};
          end else begin
            b_d = {b_q[23:0], byte_in};
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(FRAME_BYTES - 1)) begin
            state_d = ST_HOLD;
          end
        end else if (timer_expired) begin
          state_d     = ST_IDLE;
          cnt_d       = 4'd0;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (byte_valid) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Header decode, shared by IDLE and the handshake cycle of HOLD so a
    // header arriving with the handshake starts the next frame directly.
    if (byte_valid && ((state_q == ST_IDLE) || handshake)) begin
      if (byte_in[7:2] == 6'd0) begin
        op_d    = byte_in[1:0];
        cnt_d   = 4'd1;
        state_d = ST_COLLECT;
      end else begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_HEADER;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      cnt_q       <= 4'd0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign frame_valid = (state_q == ST_HOLD);
  assign busy        = (state_q == ST_COLLECT) || (state_q == ST_HOLD);
  assign op          = op_q;
  assign operand_a   = a_q;
  assign operand_b   = b_q;
  assign byte_count  = cnt_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler (TIMEOUT_CYCLES = 50).
// Stimulus pushes expected frames/errors; a negedge monitor pops and compares.
module tb_uart_frame_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        frame_ready;
  logic        frame_valid;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  byte_count;
  logic        busy;
  logic        err_pulse;
  logic [1:0]  err_code;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } frame_t;

  frame_t     exp_frames[$];
  logic [1:0] exp_errs[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_frame_assembler #(.TIMEOUT_CYCLES(50)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .frame_ready(frame_ready),
    .frame_valid(frame_valid),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .byte_count (byte_count),
    .busy       (busy),
    .err_pulse  (err_pulse),
    .err_code   (err_code)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every held-frame cycle is compared with the queue head, which
  // is popped on the handshake; every err_pulse pops one expected code.
  always @(negedge clk) begin
    if (frame_valid) begin
      if (exp_frames.size() == 0) begin
        check("unexpected_frame_valid", 64'd1, 64'd0);
      end else begin
        check("frame_op", {62'd0, op}, {62'd0, exp_frames[0].op});
        check("frame_a", {32'd0, operand_a}, {32'd0, exp_frames[0].a});
        check("frame_b", {32'd0, operand_b}, {32'd0, exp_frames[0].b});
        if (frame_ready) void'(exp_frames.pop_front());
      end
    end
    if (err_pulse) begin
      if (exp_errs.size() == 0) begin
        check("unexpected_err_pulse", {62'd0, err_code}, 64'd0);
      end else begin
        check("err_code", {62'd0, err_code}, {62'd0, exp_errs.pop_front()});
      end
    end
  end

  // Caller is positioned just after a rising edge; returns just after the
  // edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] a, input logic [31:0] b);
    send_byte(hdr);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(b[i*8 +: 8]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_valid"}, {63'd0, frame_valid}, 64'd0);
    check({tag, "_op"}, {62'd0, op}, 64'd0);
    check({tag, "_operand_a"}, {32'd0, operand_a}, 64'd0);
    check({tag, "_operand_b"}, {32'd0, operand_b}, 64'd0);
    check({tag, "_byte_count"}, {60'd0, byte_count}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_err_pulse"}, {63'd0, err_pulse}, 64'd0);
    check({tag, "_err_code"}, {62'd0, err_code}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    byte_in     = 8'h00;
    byte_valid  = 1'b0;
    frame_ready = 1'b0;
    idle(3);
    check_all_zero("reset");
    reset = 1'b1;
    idle(2);

    // Basic frame, downstream always ready: valid for exactly one cycle.
    frame_ready = 1'b1;
    exp_frames.push_back('{2'b01, 32'h3F80_0000, 32'h4000_0000});
    send_frame(8'h01, 32'h3F80_0000, 32'h4000_0000);
    check("t1_valid_after_byte9", {63'd0, frame_valid}, 64'd1);
    check("t1_count_9", {60'd0, byte_count}, 64'd9);
    idle(1);
    check("t1_valid_dropped", {63'd0, frame_valid}, 64'd0);
    check("t1_count_cleared", {60'd0, byte_count}, 64'd0);
    idle(3);

    // Held frame under backpressure, with an overrun byte mid-hold.
    frame_ready = 1'b0;
    exp_frames.push_back('{2'b01, 32'h3F80_0000, 32'h4000_0000});
    send_frame(8'h01, 32'h3F80_0000, 32'h4000_0000);
    idle(10);
    exp_errs.push_back(2'b11);
    send_byte(8'hAA);
    idle(9);
    check("t2_a_after_overrun", {32'd0, operand_a}, 64'h3F80_0000);
    check("t2_still_valid", {63'd0, frame_valid}, 64'd1);
    check("t2_err_code_held", {62'd0, err_code}, 64'd3);
    frame_ready = 1'b1;
    idle(1);
    check("t2_valid_dropped", {63'd0, frame_valid}, 64'd0);
    check("t2_busy_dropped", {63'd0, busy}, 64'd0);
    idle(2);

    // Timeout after three bytes: still collecting after 49 idle cycles,
    // timed out after the 50th.
    exp_errs.push_back(2'b01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    check("t3_count_3", {60'd0, byte_count}, 64'd3);
    idle(49);
    check("t3_busy_before_expiry", {63'd0, busy}, 64'd1);
    idle(1);
    check("t3_busy_after_expiry", {63'd0, busy}, 64'd0);
    check("t3_count_after_expiry", {60'd0, byte_count}, 64'd0);
    check("t3_err_pulse", {63'd0, err_pulse}, 64'd1);
    idle(2);
    exp_frames.push_back('{2'b10, 32'hCAFE_F00D, 32'h0123_4567});
    send_frame(8'h02, 32'hCAFE_F00D, 32'h0123_4567);
    idle(3);

    // Byte arriving in the expiry cycle is accepted; no timeout.
    exp_frames.push_back('{2'b00, 32'hA1A2_A3A4, 32'hB1B2_B3B4});
    send_byte(8'h00);
    idle(49);
    send_byte(8'hA1);
    check("t3b_count_2", {60'd0, byte_count}, 64'd2);
    check("t3b_busy", {63'd0, busy}, 64'd1);
    send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
    idle(3);

    // Bad header dropped, next frame is clean.
    exp_errs.push_back(2'b10);
    send_byte(8'h84);
    check("t4_busy", {63'd0, busy}, 64'd0);
    check("t4_count", {60'd0, byte_count}, 64'd0);
    check("t4_err_code", {62'd0, err_code}, 64'd2);
    exp_frames.push_back('{2'b00, 32'h1234_5678, 32'h9ABC_DEF0});
    send_frame(8'h00, 32'h1234_5678, 32'h9ABC_DEF0);
    idle(3);

    // Reset after byte 5 discards silently; strobes during reset ignored.
    send_byte(8'h03);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    reset = 1'b0;
    idle(1);
    check_all_zero("t5_reset");
    byte_valid = 1'b1;
    byte_in    = 8'h00;
    idle(1);
    byte_valid = 1'b0;
    check("t5_busy_ignored", {63'd0, busy}, 64'd0);
    check("t5_count_ignored", {60'd0, byte_count}, 64'd0);
    reset = 1'b1;
    idle(1);
    exp_frames.push_back('{2'b11, 32'hDEAD_BEEF, 32'hCAFE_BABE});
    send_frame(8'h03, 32'hDEAD_BEEF, 32'hCAFE_BABE);
    idle(3);

    // Back-to-back: next header strobed in the handshake cycle.
    frame_ready = 1'b0;
    exp_frames.push_back('{2'b01, 32'h0000_0001, 32'h0000_0002});
    exp_frames.push_back('{2'b00, 32'h0000_0003, 32'h0000_0004});
    send_frame(8'h01, 32'h0000_0001, 32'h0000_0002);
    idle(2);
    frame_ready = 1'b1;
    send_byte(8'h00);
    check("t6_valid_after_hs", {63'd0, frame_valid}, 64'd0);
    check("t6_count_1", {60'd0, byte_count}, 64'd1);
    check("t6_busy", {63'd0, busy}, 64'd1);
    check("t6_op_new", {62'd0, op}, 64'd0);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h0000_0003 >> (i*8)));
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h0000_0004 >> (i*8)));
    idle(4);

    check("frames_left", 64'(exp_frames.size()), 64'd0);
    check("errs_left", 64'(exp_errs.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
